// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned WIDTH x WIDTH shift-and-add multiplier.
// It drives an external WIDTH-bit ripple-carry adder. Each RUN cycle performs
// one partial-product add through that adder, then shifts {cout,sum,Q} right
// by one bit. After WIDTH iterations, {acc,Q} holds the full product.
//
// Ports:
//   clk, reset               rising-edge clock, async active-high reset
//   start                    request a multiply (sampled in IDLE/DONE only)
//   multiplicand, multiplier operands, captured on an accepted start
//   busy                     high while iterating (state RUN)
//   done                     one-cycle pulse when product updates (state DONE)
//   product                  registered 2*WIDTH-bit result, held until next done
//   add_a, add_b, add_cin    to adder: accumulator, gated multiplicand, 0
//   add_sum, add_cout        from adder
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH-1:0]   shifted;

  // Adder drive is purely combinational from registers in every state.
  assign add_a   = acc_q;
  assign add_b   = q_q[0] ? m_q : '0;
  assign add_cin = 1'b0;

  // The 2*WIDTH+1-bit {cout,sum,Q} shifted right by one; Q[0] is dropped,
  // cout lands in acc MSB so no carry is ever lost.
  assign shifted = {add_cout, add_sum, q_q[WIDTH-1:1]};

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          acc_d   = '0;
          count_d = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        {acc_d, q_d} = shifted;
        count_d      = count_q + 1'b1;
        if (count_q == LAST) begin
          product_d = shifted;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult. The external 8-bit adder is modelled
// behaviourally here; all expected products are hand-computed constants.
module tb_shift_add_mult;

  logic        clk, reset, start;
  logic [7:0]  multiplicand, multiplier;
  logic        busy, done;
  logic [15:0] product;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int checks = 0;
  int errors = 0;

  shift_add_mult #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Ripple-carry adder stand-in.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start for exactly one edge (E0) with the given operands.
  task automatic launch(input logic [7:0] m, input logic [7:0] q);
    start = 1'b1; multiplicand = m; multiplier = q;
    step();
    start = 1'b0; multiplicand = 8'hxx; multiplier = 8'hxx;
  endtask

  // Step until done, bounded; returns number of edges taken.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; multiplicand = 8'h00; multiplier = 8'h00;
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
    end
    checks++;
    if (add_a !== 8'h00 || add_b !== 8'h00 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_adder: a=%h b=%h cin=%b, want 00 00 0", add_a, add_b, add_cin);
    end
    step();
    reset = 1'b0;
    step(); step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int n, busy_bad;
    launch(8'h0F, 8'h0F);
    n = 0; busy_bad = 0;
    while (!done && n < 20) begin
      if (busy !== 1'b1) busy_bad++;
      step();
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL basic_latency: done after %0d edges past start edge, want 8", n);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL basic_busy: busy low in %0d RUN cycles, want 0", busy_bad);
    end
    checks++;
    if (product !== 16'h00E1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_product: product=%h busy=%b, want 00e1 0", product, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || product !== 16'h00E1) begin
      errors++;
      $display("FAIL basic_hold: done=%b product=%h, want 0 00e1", done, product);
    end
  endtask

  task automatic test_max();
    int n;
    launch(8'hFF, 8'hFF);
    // Iteration 1: 0+FF, no carry. Iteration 2: 7F+FF = 17E, carry out.
    checks++;
    if (add_a !== 8'h00 || add_b !== 8'hFF || add_cout !== 1'b0) begin
      errors++;
      $display("FAIL max_iter1: a=%h b=%h cout=%b, want 00 ff 0", add_a, add_b, add_cout);
    end
    step();
    checks++;
    if (add_a !== 8'h7F || add_cout !== 1'b1) begin
      errors++;
      $display("FAIL max_iter2: a=%h cout=%b, want 7f 1", add_a, add_cout);
    end
    step();
    checks++;
    if (add_a !== 8'hBF) begin
      errors++;
      $display("FAIL max_carry_in_msb: a=%h, want bf", add_a);
    end
    wait_done(n);
    checks++;
    if (n != 6 || product !== 16'hFE01) begin
      errors++;
      $display("FAIL max_product: edges=%0d product=%h, want 6 fe01", n, product);
    end
    step();
  endtask

  task automatic test_zero_gating();
    logic [7:0] exp_b;
    int bad_b, bad_cin;
    // 0x80 x 0x02: Q[0] is 1 only in the second iteration.
    launch(8'h80, 8'h02);
    bad_b = 0; bad_cin = 0;
    for (int c = 1; c <= 8; c++) begin
      exp_b = (c == 2) ? 8'h80 : 8'h00;
      if (add_b !== exp_b) bad_b++;
      if (add_cin !== 1'b0) bad_cin++;
      step();
    end
    checks++;
    if (bad_b != 0 || bad_cin != 0) begin
      errors++;
      $display("FAIL gating_80x02: bad add_b=%0d bad add_cin=%0d, want 0 0", bad_b, bad_cin);
    end
    checks++;
    if (done !== 1'b1 || product !== 16'h0100) begin
      errors++;
      $display("FAIL product_80x02: done=%b product=%h, want 1 0100", done, product);
    end
    step();
    launch(8'h00, 8'hA5);
    bad_b = 0; bad_cin = 0;
    for (int c = 1; c <= 8; c++) begin
      if (add_b !== 8'h00) bad_b++;
      if (add_cin !== 1'b0) bad_cin++;
      step();
    end
    checks++;
    if (bad_b != 0 || bad_cin != 0 || done !== 1'b1 || product !== 16'h0000) begin
      errors++;
      $display("FAIL zero_00xa5: bad_b=%0d bad_cin=%0d done=%b product=%h, want 0 0 1 0000",
               bad_b, bad_cin, done, product);
    end
    step();
  endtask

  task automatic test_start_ignored();
    int pulses, first;
    launch(8'h03, 8'h05);
    start = 1'b1; multiplicand = 8'hFF; multiplier = 8'hFF;
    step(); step(); step();
    start = 1'b0;
    pulses = 0; first = -1;
    for (int c = 4; c <= 16; c++) begin
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
        checks++;
        if (product !== 16'h000F) begin
          errors++;
          $display("FAIL ignore_product: product=%h, want 000f", product);
        end
      end
      step();
    end
    checks++;
    if (pulses != 1 || first != 9) begin
      errors++;
      $display("FAIL ignore_done: pulses=%0d at cycle %0d, want 1 at 9", pulses, first);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    launch(8'h12, 8'h34);
    wait_done(n);
    checks++;
    if (n != 8 || product !== 16'h03A8) begin
      errors++;
      $display("FAIL b2b_first: edges=%0d product=%h, want 8 03a8", n, product);
    end
    launch(8'h02, 8'h03);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || product !== 16'h03A8) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b product=%h, want 1 0 03a8", busy, done, product);
    end
    wait_done(n);
    checks++;
    if (n != 8 || product !== 16'h0006) begin
      errors++;
      $display("FAIL b2b_second: edges=%0d product=%h, want 8 0006", n, product);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    launch(8'hFF, 8'hFF);
    step(); step(); step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000 || add_a !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b product=%h a=%h, want 0 0 0000 00",
               busy, done, product, add_a);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: busy=%b done=%b, want 0 0", busy, done);
    end
    #2 reset = 1'b0;
    step();
    launch(8'h02, 8'h02);
    wait_done(n);
    checks++;
    if (n != 8 || product !== 16'h0004) begin
      errors++;
      $display("FAIL post_reset: edges=%0d product=%h, want 8 0004", n, product);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_gating();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
